// File: rtl/slot_bus_scheduler.sv
// slot_bus_scheduler
// Time-slot sequencer and shared memory bus arbiter. Time is divided into
// NUM_SLOTS slots of SLOT_LEN clocks each. Only enabled slots are visited.
// The owner of the active slot may issue one memory request per visit, and the
// response is routed back to that owner. Responses that arrive late or were
// never requested set a sticky error flag.
//
// Ports
//   clk_100mhz  : system clock
//   rst_n       : asynchronous active-low reset
//   slot_en     : per-slot enable, sampled only at slot boundaries
//   hold        : freezes the slot/cycle counters and suppresses tick/wrap/mem_req
//   req         : per-channel memory request
//   addr        : per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   slot_active : one-hot owner of the current slot, 0 when idle
//   tick        : 1-clock strobe on the first clock of a slot
//   wrap        : 1-clock strobe with a tick whose slot index <= previous index
//   mem_req     : 1-clock memory request strobe
//   mem_addr    : address of the last issued request, held
//   mem_data    : memory read data
//   mem_valid   : memory read data valid strobe
//   data        : last accepted read data, held
//   data_valid  : 1-clock strobe to the channel that owns the response
//   late_err    : sticky flag for dropped or unsolicited responses
module slot_bus_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_LEN  = 8,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic                          clk_100mhz,
    input  logic                          rst_n,
    input  logic [NUM_SLOTS-1:0]          slot_en,
    input  logic                          hold,
    input  logic [NUM_SLOTS-1:0]          req,
    input  logic [NUM_SLOTS*ADDR_W-1:0]   addr,
    output logic [NUM_SLOTS-1:0]          slot_active,
    output logic [NUM_SLOTS-1:0]          tick,
    output logic                          wrap,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_data,
    input  logic                          mem_valid,
    output logic [DATA_W-1:0]             data,
    output logic [NUM_SLOTS-1:0]          data_valid,
    output logic                          late_err
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] LAST_CYC = CW'(SLOT_LEN - 1);

    logic [SW-1:0]        slot;
    logic [SW-1:0]        next_slot;
    logic [SW-1:0]        cand;
    logic [CW-1:0]        cyc;
    logic                 active;
    logic                 outstanding;
    logic                 wrap_q;
    logic                 mem_req_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    data_q;
    logic [NUM_SLOTS-1:0] data_valid_q;
    logic                 late_err_q;
    logic [NUM_SLOTS-1:0] slot_onehot;
    logic [ADDR_W-1:0]    addr_ch [NUM_SLOTS];
    logic                 boundary;
    logic                 issue;

    assign slot_onehot = NUM_SLOTS'(1) << slot;
    assign boundary    = !hold && (cyc == LAST_CYC);
    assign issue       = !hold && active && (cyc == '0) && req[slot];

    // Unpack the flat address bus so the owning channel can be selected by slot.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            addr_ch[i] = addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin successor: walk downwards from the farthest offset so that the
    // nearest enabled slot after the current one wins; the current slot itself
    // (offset NUM_SLOTS) is the last resort. With nothing enabled, stay put.
    always_comb begin
        next_slot = slot;
        cand      = '0;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            cand = SW'((int'(slot) + k) % NUM_SLOTS);
            if (slot_en[cand]) begin
                next_slot = cand;
            end
        end
    end

    // Slot/cycle counters. Reset parks at the last cycle of the last slot so the
    // first clock after reset is a boundary that picks the lowest enabled slot.
    // wrap is only raised when moving from an active slot into an active slot.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= SW'(NUM_SLOTS - 1);
            cyc    <= LAST_CYC;
            active <= 1'b0;
            wrap_q <= 1'b0;
        end else if (!hold) begin
            if (cyc == LAST_CYC) begin
                cyc    <= '0;
                slot   <= next_slot;
                active <= |slot_en;
                wrap_q <= active && (|slot_en) && (next_slot <= slot);
            end else begin
                cyc    <= cyc + CW'(1);
                wrap_q <= 1'b0;
            end
        end
    end

    // Memory bus: a request launches on the cycle 0 -> 1 step of an active slot.
    // A response is accepted whenever one is outstanding, even during hold or on
    // the boundary clock itself; reaching a boundary still waiting drops it.
    // The issue assignment comes last because it must win over a stray response
    // clearing outstanding on the same clock.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            outstanding  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            data_q       <= '0;
            data_valid_q <= '0;
            late_err_q   <= 1'b0;
        end else begin
            mem_req_q    <= 1'b0;
            data_valid_q <= '0;
            if (mem_valid) begin
                if (outstanding && active) begin
                    data_q       <= mem_data;
                    data_valid_q <= slot_onehot;
                    outstanding  <= 1'b0;
                end else begin
                    late_err_q <= 1'b1;
                end
            end else if (boundary && outstanding) begin
                outstanding <= 1'b0;
                late_err_q  <= 1'b1;
            end
            if (issue) begin
                mem_req_q   <= 1'b1;
                mem_addr_q  <= addr_ch[slot];
                outstanding <= 1'b1;
            end
        end
    end

    // Tick and wrap are gated by hold so a frozen first cycle produces no strobe
    // until the counters move again.
    always_comb begin
        slot_active = active ? slot_onehot : '0;
        tick        = ((cyc == '0) && !hold) ? slot_active : '0;
        wrap        = wrap_q && !hold;
        mem_req     = mem_req_q;
        mem_addr    = mem_addr_q;
        data        = data_q;
        data_valid  = data_valid_q;
        late_err    = late_err_q;
    end

endmodule

// File: tb/tb_slot_bus_scheduler.sv
// tb_slot_bus_scheduler
// Directed bench for slot_bus_scheduler with the default parameters
// (4 slots of 8 clocks, 16-bit address, 8-bit data). Clock numbers in the
// comments count rising edges after reset release; outputs are sampled 1 ns
// after each rising edge and inputs are changed at that same point.
module tb_slot_bus_scheduler;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_LEN  = 8;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;

    logic                        clk_100mhz;
    logic                        rst_n;
    logic [NUM_SLOTS-1:0]        slot_en;
    logic                        hold;
    logic [NUM_SLOTS-1:0]        req;
    logic [NUM_SLOTS*ADDR_W-1:0] addr;
    logic [NUM_SLOTS-1:0]        slot_active;
    logic [NUM_SLOTS-1:0]        tick;
    logic                        wrap;
    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_data;
    logic                        mem_valid;
    logic [DATA_W-1:0]           data;
    logic [NUM_SLOTS-1:0]        data_valid;
    logic                        late_err;

    int vectors;
    int miscompares;

    slot_bus_scheduler #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_LEN  (SLOT_LEN),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .slot_en     (slot_en),
        .hold        (hold),
        .req         (req),
        .addr        (addr),
        .slot_active (slot_active),
        .tick        (tick),
        .wrap        (wrap),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .data        (data),
        .data_valid  (data_valid),
        .late_err    (late_err)
    );

    // 100 MHz clock.
    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitClocks(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_SLOTS-1:0] en_v,
                                 input logic hold_v,
                                 input logic [NUM_SLOTS-1:0] req_v);
        slot_en = en_v;
        hold    = hold_v;
        req     = req_v;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every output must read zero while reset is applied.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".slot_active"}, 32'(slot_active), 32'h0);
        checkOutput({tag, ".tick"},        32'(tick),        32'h0);
        checkOutput({tag, ".wrap"},        32'(wrap),        32'h0);
        checkOutput({tag, ".mem_req"},     32'(mem_req),     32'h0);
        checkOutput({tag, ".mem_addr"},    32'(mem_addr),    32'h0);
        checkOutput({tag, ".data"},        32'(data),        32'h0);
        checkOutput({tag, ".data_valid"},  32'(data_valid),  32'h0);
        checkOutput({tag, ".late_err"},    32'(late_err),    32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        mem_data    = '0;
        mem_valid   = 1'b0;
        addr        = '0;
        applyStimulus(4'b1111, 1'b0, 4'b0000);

        // Reset state.
        waitClocks(2);
        checkAllZero("reset");
        rst_n = 1'b1;

        // All slots enabled: ticks every 8 clocks, wrap only once slot 3 -> 0.
        waitClocks(1);                                   // clk 1
        checkOutput("tick_c1",  32'(tick), 32'h1);
        checkOutput("wrap_c1",  32'(wrap), 32'h0);
        checkOutput("act_c1",   32'(slot_active), 32'h1);
        waitClocks(1);                                   // clk 2
        checkOutput("tick_c2",  32'(tick), 32'h0);
        checkOutput("act_c2",   32'(slot_active), 32'h1);
        waitClocks(7);                                   // clk 9
        checkOutput("tick_c9",  32'(tick), 32'h2);
        waitClocks(8);                                   // clk 17
        checkOutput("tick_c17", 32'(tick), 32'h4);
        waitClocks(8);                                   // clk 25
        checkOutput("tick_c25", 32'(tick), 32'h8);
        checkOutput("wrap_c25", 32'(wrap), 32'h0);
        waitClocks(8);                                   // clk 33
        checkOutput("tick_c33", 32'(tick), 32'h1);
        checkOutput("wrap_c33", 32'(wrap), 32'h1);

        // Mask 1010 changed mid-slot: slot 0 completes, then 1/3 alternate.
        applyStimulus(4'b1010, 1'b0, 4'b0000);
        waitClocks(7);                                   // clk 40
        checkOutput("act_c40",  32'(slot_active), 32'h1);
        waitClocks(1);                                   // clk 41
        checkOutput("tick_c41", 32'(tick), 32'h2);
        checkOutput("wrap_c41", 32'(wrap), 32'h0);
        waitClocks(8);                                   // clk 49
        checkOutput("tick_c49", 32'(tick), 32'h8);
        checkOutput("wrap_c49", 32'(wrap), 32'h0);
        waitClocks(4);                                   // clk 53
        checkOutput("act_c53",  32'(slot_active), 32'h8);
        waitClocks(4);                                   // clk 57
        checkOutput("tick_c57", 32'(tick), 32'h2);
        checkOutput("wrap_c57", 32'(wrap), 32'h1);
        waitClocks(8);                                   // clk 65
        checkOutput("tick_c65", 32'(tick), 32'h8);

        // Back to all enabled; hold 5 clocks at cycle 3 of slot 2.
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        waitClocks(8);                                   // clk 73
        checkOutput("tick_c73", 32'(tick), 32'h1);
        checkOutput("wrap_c73", 32'(wrap), 32'h1);
        waitClocks(16);                                  // clk 89
        checkOutput("tick_c89", 32'(tick), 32'h4);
        waitClocks(3);                                   // clk 92, cycle 3
        applyStimulus(4'b1111, 1'b1, 4'b0000);
        waitClocks(3);                                   // clk 95
        checkOutput("tick_hold", 32'(tick), 32'h0);
        checkOutput("act_hold",  32'(slot_active), 32'h4);
        waitClocks(2);                                   // clk 97
        checkOutput("tick_c97",  32'(tick), 32'h0);
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        waitClocks(4);                                   // clk 101
        checkOutput("tick_c101", 32'(tick), 32'h0);
        checkOutput("act_c101",  32'(slot_active), 32'h4);
        waitClocks(1);                                   // clk 102
        checkOutput("tick_c102", 32'(tick), 32'h8);

        // Channel 1 request, answered 2 clocks after mem_req.
        addr[1*ADDR_W +: ADDR_W] = 16'hC0DE;
        applyStimulus(4'b1111, 1'b0, 4'b0010);
        waitClocks(1);                                   // clk 103, slot 3
        checkOutput("mreq_c103", 32'(mem_req), 32'h0);
        waitClocks(15);                                  // clk 118
        checkOutput("tick_c118", 32'(tick), 32'h2);
        checkOutput("mreq_c118", 32'(mem_req), 32'h0);
        waitClocks(1);                                   // clk 119
        checkOutput("mreq_c119", 32'(mem_req), 32'h1);
        checkOutput("maddr_c119", 32'(mem_addr), 32'hC0DE);
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        waitClocks(1);                                   // clk 120
        checkOutput("mreq_c120", 32'(mem_req), 32'h0);
        waitClocks(1);                                   // clk 121
        mem_valid = 1'b1;
        mem_data  = 8'h5A;
        waitClocks(1);                                   // clk 122
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        checkOutput("data_c122", 32'(data), 32'h5A);
        checkOutput("dv_c122",   32'(data_valid), 32'h2);
        waitClocks(1);                                   // clk 123
        checkOutput("dv_c123",   32'(data_valid), 32'h0);
        checkOutput("data_c123", 32'(data), 32'h5A);
        checkOutput("err_c123",  32'(late_err), 32'h0);
        checkOutput("maddr_c123", 32'(mem_addr), 32'hC0DE);

        // Channel 2 request never answered: dropped at the slot boundary.
        addr[2*ADDR_W +: ADDR_W] = 16'h1234;
        applyStimulus(4'b1111, 1'b0, 4'b0100);
        waitClocks(3);                                   // clk 126
        checkOutput("tick_c126", 32'(tick), 32'h4);
        waitClocks(1);                                   // clk 127
        checkOutput("mreq_c127",  32'(mem_req), 32'h1);
        checkOutput("maddr_c127", 32'(mem_addr), 32'h1234);
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        waitClocks(6);                                   // clk 133
        checkOutput("err_c133", 32'(late_err), 32'h0);
        waitClocks(1);                                   // clk 134
        checkOutput("err_c134",  32'(late_err), 32'h1);
        checkOutput("dv_c134",   32'(data_valid), 32'h0);
        checkOutput("tick_c134", 32'(tick), 32'h8);
        mem_valid = 1'b1;
        mem_data  = 8'h77;
        waitClocks(1);                                   // clk 135
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        checkOutput("err_stray",  32'(late_err), 32'h1);
        checkOutput("data_stray", 32'(data), 32'h5A);
        checkOutput("dv_stray",   32'(data_valid), 32'h0);

        // Nothing enabled: slot 3 finishes, then idle with requests ignored.
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        waitClocks(6);                                   // clk 141
        checkOutput("act_c141", 32'(slot_active), 32'h8);
        applyStimulus(4'b0000, 1'b0, 4'b1111);
        waitClocks(1);                                   // clk 142
        checkOutput("act_idle",  32'(slot_active), 32'h0);
        checkOutput("tick_idle", 32'(tick), 32'h0);
        waitClocks(1);                                   // clk 143
        checkOutput("mreq_idle", 32'(mem_req), 32'h0);
        waitClocks(7);                                   // clk 150
        checkOutput("act_c150",  32'(slot_active), 32'h0);
        checkOutput("tick_c150", 32'(tick), 32'h0);

        // Re-enable slot 0 only: first visit has no wrap, the repeat visit does.
        applyStimulus(4'b0001, 1'b0, 4'b0000);
        waitClocks(8);                                   // clk 158
        checkOutput("tick_c158", 32'(tick), 32'h1);
        checkOutput("wrap_c158", 32'(wrap), 32'h0);
        waitClocks(8);                                   // clk 166
        checkOutput("tick_c166", 32'(tick), 32'h1);
        checkOutput("wrap_c166", 32'(wrap), 32'h1);

        // Reset in the middle of a request clears everything immediately.
        addr[0*ADDR_W +: ADDR_W] = 16'hABCD;
        applyStimulus(4'b0001, 1'b0, 4'b0001);
        waitClocks(1);                                   // clk 167
        checkOutput("mreq_c167",  32'(mem_req), 32'h1);
        checkOutput("maddr_c167", 32'(mem_addr), 32'hABCD);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        waitClocks(1);
        rst_n = 1'b1;
        waitClocks(1);                                   // clk 1 after restart
        checkOutput("restart_tick1", 32'(tick), 32'h1);
        checkOutput("restart_wrap1", 32'(wrap), 32'h0);
        waitClocks(8);                                   // clk 9 after restart
        checkOutput("restart_tick9", 32'(tick), 32'h2);
        checkOutput("restart_err",   32'(late_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
